// File: rtl/vsq_ctrl_pkg.sv
// Shared widths and FSM encoding for the VSQ accumulation sequencer.
// The optional saturation mode is selected with the VSQ_SAT_EN macro (see vsq_scale_mac).
package vsq_ctrl_pkg;

  localparam int ACC_W   = 24;
  localparam int INT4_W  = 14;
  localparam int SCALE_W = 8;
  localparam int PROD_W  = 22;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCUM  = 2'd1,
    ST_RESULT = 2'd2
  } vsq_state_t;

endpackage : vsq_ctrl_pkg

// File: rtl/vsq_scale_mac.sv
// Combinational scale-and-accumulate step: sp = a*b mod 2^8, m = int4*sp, acc + m.
// VSQ_SAT_EN defined: clamp to all-ones on carry-out; undefined: wrap modulo 2^ACC_W.
module vsq_scale_mac
  import vsq_ctrl_pkg::*;
(
  input  logic               vsq,
  input  logic [INT4_W-1:0]  int4,
  input  logic [SCALE_W-1:0] scale_a,
  input  logic [SCALE_W-1:0] scale_b,
  input  logic [ACC_W-1:0]   acc,
  output logic [ACC_W-1:0]   acc_next,
  output logic               carry
);

  logic [SCALE_W-1:0] sp_raw;
  logic [SCALE_W-1:0] sp;
  logic [PROD_W-1:0]  prod;
  logic [ACC_W:0]     sum_wide;

  // An 8-bit product context keeps only the low byte; the carry is dropped on purpose.
  assign sp_raw   = scale_a * scale_b;
  assign sp       = vsq ? sp_raw : '0;
  assign prod     = {{(PROD_W-INT4_W){1'b0}}, int4} * {{(PROD_W-SCALE_W){1'b0}}, sp};
  assign sum_wide = {1'b0, acc} + {{(ACC_W+1-PROD_W){1'b0}}, prod};
  assign carry    = sum_wide[ACC_W];

`ifdef VSQ_SAT_EN
  // Once clamped, any further non-zero product carries again, so the clamp holds.
  assign acc_next = carry ? {ACC_W{1'b1}} : sum_wide[ACC_W-1:0];
`else
  assign acc_next = sum_wide[ACC_W-1:0];
`endif

endmodule : vsq_scale_mac

// File: rtl/vsq_accum_ctrl.sv
// Sequencer for one VSQ accumulation job: latches the job, accumulates len beats, presents the sum.
// Saturating accumulation is enabled by defining VSQ_SAT_EN.
module vsq_accum_ctrl
  import vsq_ctrl_pkg::*;
#(
  parameter int LEN_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_vsq,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INT4_W-1:0]  in_int4,
  input  logic [SCALE_W-1:0] in_a,
  input  logic [SCALE_W-1:0] in_b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ACC_W-1:0]   out_sum,
  output logic               out_ovf,
  output logic               busy
);

  vsq_state_t       state_reg, state_next;
  logic [LEN_W-1:0] len_reg;
  logic [LEN_W-1:0] cnt_reg;
  logic [LEN_W-1:0] cnt_next;
  logic             vsq_reg;
  logic [ACC_W-1:0] acc_reg;
  logic             ovf_reg;

  logic             start_accept;
  logic             in_hs;
  logic             last_beat;
  logic [ACC_W-1:0] mac_acc_next;
  logic             mac_carry;

  vsq_scale_mac u_mac (
    .vsq      (vsq_reg),
    .int4     (in_int4),
    .scale_a  (in_a),
    .scale_b  (in_b),
    .acc      (acc_reg),
    .acc_next (mac_acc_next),
    .carry    (mac_carry)
  );

  // Handshake-facing outputs decode straight from the state register.
  assign in_ready  = (state_reg == ST_ACCUM);
  assign out_valid = (state_reg == ST_RESULT);
  assign busy      = (state_reg != ST_IDLE);
  assign out_sum   = acc_reg;
  assign out_ovf   = ovf_reg;

  assign start_accept = (state_reg == ST_IDLE) && start;
  assign in_hs        = in_valid && in_ready;
  assign cnt_next     = cnt_reg + LEN_W'(1);
  assign last_beat    = (cnt_next == len_reg);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          state_next = (cfg_len == '0) ? ST_RESULT : ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        if (in_hs && last_beat) begin
          state_next = ST_RESULT;
        end
      end
      ST_RESULT: begin
        if (out_ready) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Accumulator and flag only move in IDLE (cleared on start) and on input beats,
  // so they stay frozen for the whole RESULT phase.
  always_ff @(posedge clk) begin
    if (rst) begin
      len_reg <= '0;
      cnt_reg <= '0;
      vsq_reg <= 1'b0;
      acc_reg <= '0;
      ovf_reg <= 1'b0;
    end else if (start_accept) begin
      len_reg <= cfg_len;
      cnt_reg <= '0;
      vsq_reg <= cfg_vsq;
      acc_reg <= '0;
      ovf_reg <= 1'b0;
    end else if (in_hs) begin
      cnt_reg <= cnt_next;
      acc_reg <= mac_acc_next;
      ovf_reg <= ovf_reg | mac_carry;
    end
  end

endmodule : vsq_accum_ctrl

// File: tb/tb_vsq_accum_ctrl.sv
// Self-checking bench for vsq_accum_ctrl: directed jobs plus randomized jobs against a sum model.
// Expected results follow VSQ_SAT_EN when the macro is defined.
module tb_vsq_accum_ctrl;

  localparam int LEN_W = 8;
  localparam longint ACC_MAX = 64'd16777215;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [LEN_W-1:0] cfg_len;
  logic        cfg_vsq;
  logic        in_valid;
  logic        in_ready;
  logic [13:0] in_int4;
  logic [7:0]  in_a;
  logic [7:0]  in_b;
  logic        out_valid;
  logic        out_ready;
  logic [23:0] out_sum;
  logic        out_ovf;
  logic        busy;

  int err_cnt = 0;
  int chk_cnt = 0;
  int job_cnt = 0;

  int b_i4 [256];
  int b_a  [256];
  int b_b  [256];

  vsq_accum_ctrl #(.LEN_W(LEN_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .cfg_len   (cfg_len),
    .cfg_vsq   (cfg_vsq),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_int4   (in_int4),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_ovf   (out_ovf),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Mix of full-range values and maxima so overflow is hit regularly.
  task automatic fill_random(input int len);
    for (int i = 0; i < len; i++) begin
      if ($urandom_range(3) == 0) begin
        b_i4[i] = 16383; b_a[i] = 255; b_b[i] = 1;
      end else begin
        b_i4[i] = int'($urandom_range(16383));
        b_a[i]  = int'($urandom_range(255));
        b_b[i]  = int'($urandom_range(255));
      end
    end
  endtask

  function automatic longint model_total(input int len, input bit vsq);
    longint total = 0;
    for (int i = 0; i < len; i++) begin
      if (vsq) total += longint'(b_i4[i]) * longint'((b_a[i] * b_b[i]) % 256);
    end
    return total;
  endfunction

  task automatic run_job(input int len, input bit vsq, input int prob,
                         input int hold, input bit stray);
    longint total;
    longint exp_sum;
    bit     exp_ovf;
    bit     hs;
    int     idx = 0;
    int     cyc = 0;
    total = model_total(len, vsq);
`ifdef VSQ_SAT_EN
    exp_sum = (total > ACC_MAX) ? ACC_MAX : total;
`else
    exp_sum = total % (ACC_MAX + 1);
`endif
    exp_ovf = (total > ACC_MAX);

    check("idle_busy", 32'(busy), 32'd0);
    start = 1'b1; cfg_len = LEN_W'(len); cfg_vsq = vsq;
    tick();
    start = 1'b0;
    check("start_busy", 32'(busy), 32'd1);
    if (len == 0) begin
      check("len0_valid", 32'(out_valid), 32'd1);
      check("len0_ready", 32'(in_ready), 32'd0);
    end else begin
      check("start_ready", 32'(in_ready), 32'd1);
    end

    while (idx < len && cyc < 4000) begin
      in_valid = (int'($urandom_range(99)) < prob);
      in_int4  = 14'(b_i4[idx]);
      in_a     = 8'(b_a[idx]);
      in_b     = 8'(b_b[idx]);
      if (stray) begin
        start   = ($urandom_range(3) == 0);
        cfg_len = LEN_W'($urandom);
        cfg_vsq = 1'($urandom);
      end
      hs = in_valid && in_ready;
      check("accum_no_valid", 32'(out_valid), 32'd0);
      tick();
      if (hs) idx++;
      cyc++;
    end
    in_valid = 1'b0;
    start    = 1'b0;
    check("beats_accepted", 32'(idx), 32'(len));
    check("res_valid", 32'(out_valid), 32'd1);
    check("res_ready_low", 32'(in_ready), 32'd0);

    for (int h = 0; h < hold; h++) begin
      if (stray) begin
        start   = 1'b1;
        cfg_len = LEN_W'($urandom);
      end
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_sum", 32'(out_sum), 32'(exp_sum));
      tick();
    end
    start = 1'b0;
    check("sum", 32'(out_sum), 32'(exp_sum));
    check("ovf", 32'(out_ovf), 32'(exp_ovf));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("post_valid", 32'(out_valid), 32'd0);
    check("post_busy", 32'(busy), 32'd0);
    job_cnt++;
    $display("job %0d: len=%0d vsq=%0d sum=%0d ovf=%0d (exp %0d/%0d)",
             job_cnt, len, vsq, out_sum, out_ovf, exp_sum, exp_ovf);
  endtask

  initial begin
    int accepted;
    rst = 1'b1; start = 1'b0; cfg_len = '0; cfg_vsq = 1'b0;
    in_valid = 1'b0; in_int4 = '0; in_a = '0; in_b = '0; out_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_sum", 32'(out_sum), 32'd0);
    check("rst_out_ovf", 32'(out_ovf), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);

    // Basic two-beat job; second beat's scale wraps to zero.
    b_i4[0] = 100; b_a[0] = 3;  b_b[0] = 5;
    b_i4[1] = 10;  b_a[1] = 16; b_b[1] = 16;
    run_job(2, 1'b1, 100, 0, 1'b0);
    check("tp_basic_sum", 32'(out_sum), 32'd1500);
    check("tp_basic_ovf", 32'(out_ovf), 32'd0);

    // Overflow job.
    for (int i = 0; i < 5; i++) begin
      b_i4[i] = 16383; b_a[i] = 255; b_b[i] = 1;
    end
    run_job(5, 1'b1, 100, 1, 1'b0);
`ifdef VSQ_SAT_EN
    check("tp_ovf_sum", 32'(out_sum), 32'd16777215);
`else
    check("tp_ovf_sum", 32'(out_sum), 32'd4111109);
`endif
    check("tp_ovf_flag", 32'(out_ovf), 32'd1);

    // VSQ disabled.
    fill_random(3);
    run_job(3, 1'b0, 70, 2, 1'b0);
    check("tp_novsq_sum", 32'(out_sum), 32'd0);

    // Zero length.
    run_job(0, 1'b1, 100, 0, 1'b0);
    check("tp_len0_sum", 32'(out_sum), 32'd0);

    // Handshake stress with stray starts.
    fill_random(6);
    run_job(6, 1'b1, 50, 4, 1'b1);

    for (int j = 0; j < 25; j++) begin
      int len;
      len = int'($urandom_range(12));
      fill_random(len);
      run_job(len, 1'($urandom_range(3) != 0), 50, int'($urandom_range(4)), 1'($urandom));
    end

    // Reset mid-job after two of four beats.
    fill_random(4);
    start = 1'b1; cfg_len = 8'd4; cfg_vsq = 1'b1;
    tick();
    start = 1'b0;
    accepted = 0;
    for (int c = 0; c < 50 && accepted < 2; c++) begin
      in_valid = 1'b1;
      in_int4 = 14'(b_i4[accepted]); in_a = 8'(b_a[accepted]); in_b = 8'(b_b[accepted]);
      if (in_ready) accepted++;
      tick();
    end
    in_valid = 1'b0;
    check("mid_accepted", 32'(accepted), 32'd2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_in_ready", 32'(in_ready), 32'd0);
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_out_sum", 32'(out_sum), 32'd0);
    check("mid_rst_out_ovf", 32'(out_ovf), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    b_i4[0] = 2; b_a[0] = 2; b_b[0] = 2;
    run_job(1, 1'b1, 100, 0, 1'b0);
    check("tp_reset_sum", 32'(out_sum), 32'd8);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule : tb_vsq_accum_ctrl
